parity_frame_ctrl: RTL and testbench

PARITY_FRAME_CTRL -- requirements
Module: parity_frame_ctrl

---
 rtl/parity_frame_ctrl.sv | 92 +++++++++
 tb/tb_parity_frame_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/parity_frame_ctrl.sv
// Serial even-parity frame receiver: start, DATA_W data bits LSB first, then parity; saturating error count.
// Result is registered one cycle after the parity bit; in_ready drops while the result is held unacknowledged.
module parity_frame_ctrl #(
   parameter int DATA_W = 4,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              din,
   input  logic              din_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] data_out,
   output logic              pec,
   output logic              out_valid,
   input  logic              out_ready,
   input  logic              clr_cnt,
   output logic [CNT_W-1:0]  err_count
);

   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, DATA, PAR, HOLD} state_t;

   state_t            state;
   logic [IDX_W-1:0]  idx;
   logic              acc;
   logic [DATA_W-1:0] data_sh;
   logic              par_err;

   // Parity outcome for the bit being offered in PAR; drives both pec and the counter.
   assign par_err = acc ^ din;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         acc       <= 1'b0;
         data_sh   <= '0;
         data_out  <= '0;
         pec       <= 1'b0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         err_count <= '0;
      end else begin
         if (clr_cnt)
            err_count <= '0;
         else if (state == PAR && din_valid && par_err && err_count != '1)
            err_count <= err_count + 1'b1;

         case (state)
            IDLE: begin
               if (start) begin
                  state <= DATA;
                  idx   <= '0;
                  acc   <= 1'b0;
               end
            end
            DATA: begin
               if (din_valid) begin
                  data_sh[idx] <= din;
                  acc          <= acc ^ din;
                  if (idx == LAST_IDX)
                     state <= PAR;
                  else
                     idx <= idx + 1'b1;
               end
            end
            PAR: begin
               // data_out/pec change only here so they persist after the handshake.
               if (din_valid) begin
                  pec       <= par_err;
                  data_out  <= data_sh;
                  out_valid <= 1'b1;
                  in_ready  <= 1'b0;
                  state     <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Directed bench for parity_frame_ctrl (DATA_W=4, CNT_W=2): good/bad frames, backpressure, stalls, reset, saturation.
module tb_parity_frame_ctrl;

   logic       clk = 1'b0;
   logic       rst, start, din, din_valid, out_ready, clr_cnt;
   logic       in_ready, pec, out_valid;
   logic [3:0] data_out;
   logic [1:0] err_count;

   int n_checks = 0;
   int n_fail   = 0;

   parity_frame_ctrl #(.DATA_W(4), .CNT_W(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .din       (din),
      .din_valid (din_valid),
      .in_ready  (in_ready),
      .data_out  (data_out),
      .pec       (pec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .clr_cnt   (clr_cnt),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled on the falling edge.
   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Sends start, four data bits LSB first, then parity; each bit preceded by gap idle cycles with start pulsed.
   task automatic frame(input logic [3:0] d, input logic p, input int gap);
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         for (int g = 0; g < gap; g++) begin
            start     = 1'b1;
            din_valid = 1'b0;
            din       = ~din;
            cyc();
         end
         start     = 1'b0;
         din       = (i < 4) ? d[i] : p;
         din_valid = 1'b1;
         cyc();
         din_valid = 1'b0;
      end
   endtask

   task automatic ack(input string tag);
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      chk({tag, "_ack_vld"}, 16'(out_valid), 16'h0);
      chk({tag, "_ack_rdy"}, 16'(in_ready), 16'h1);
   endtask

   task automatic chk_result(input string tag, input logic [3:0] d, input logic e, input logic [1:0] cnt);
      chk({tag, "_vld"}, 16'(out_valid), 16'h1);
      chk({tag, "_rdy"}, 16'(in_ready), 16'h0);
      chk({tag, "_data"}, 16'(data_out), 16'(d));
      chk({tag, "_pec"}, 16'(pec), 16'(e));
      chk({tag, "_cnt"}, 16'(err_count), 16'(cnt));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; din = 1'b0; din_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
      cyc();
      cyc();
      chk("rst_rdy", 16'(in_ready), 16'h1);
      chk("rst_vld", 16'(out_valid), 16'h0);
      chk("rst_pec", 16'(pec), 16'h0);
      chk("rst_data", 16'(data_out), 16'h0);
      chk("rst_cnt", 16'(err_count), 16'h0);
      rst = 1'b0;

      // Good frame: bits 1,1,0,1 -> 4'b1011, parity 1 makes total XOR 0.
      frame(4'b1011, 1'b1, 0);
      chk_result("good", 4'b1011, 1'b0, 2'd0);
      ack("good");
      chk("good_retain_data", 16'(data_out), 16'hb);

      // Bad frame, then held for 5 cycles while din/start toggle.
      frame(4'b1011, 1'b0, 0);
      chk_result("bad", 4'b1011, 1'b1, 2'd1);
      for (int k = 0; k < 5; k++) begin
         out_ready = 1'b0; start = 1'b1; din_valid = 1'b1; din = k[0];
         cyc();
         chk_result("hold", 4'b1011, 1'b1, 2'd1);
      end
      start = 1'b0; din_valid = 1'b0;
      ack("bad");

      // Gapped frames with start pulses inside the gaps.
      frame(4'b1011, 1'b1, 1);
      chk_result("gap1", 4'b1011, 1'b0, 2'd1);
      ack("gap1");
      frame(4'b0110, 1'b0, 7);
      chk_result("gap7", 4'b0110, 1'b0, 2'd1);
      ack("gap7");

      // Reset after two data bits, then an immediate new frame.
      start = 1'b1;
      cyc();
      start = 1'b0; din_valid = 1'b1; din = 1'b1;
      cyc();
      cyc();
      din_valid = 1'b0; rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("mrst_rdy", 16'(in_ready), 16'h1);
      chk("mrst_vld", 16'(out_valid), 16'h0);
      chk("mrst_cnt", 16'(err_count), 16'h0);
      chk("mrst_data", 16'(data_out), 16'h0);
      frame(4'b0101, 1'b0, 0);
      chk_result("post_rst", 4'b0101, 1'b0, 2'd0);
      ack("post_rst");

      // Counter saturates at 3 for a 2-bit counter.
      for (int k = 1; k <= 5; k++) begin
         frame(4'b1011, 1'b0, 0);
         chk("sat_cnt", 16'(err_count), 16'((k > 3) ? 3 : k));
         ack("sat");
      end

      // Clear wins over an increment landing on the same edge; FSM still completes.
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         din = (i == 2) ? 1'b0 : 1'b1; din_valid = 1'b1;
         cyc();
      end
      din = 1'b0; clr_cnt = 1'b1;
      cyc();
      din_valid = 1'b0; clr_cnt = 1'b0;
      chk_result("clr", 4'b1011, 1'b1, 2'd0);
      ack("clr");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
